// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_pkg;

    // Register-file index width (16 architectural registers).
    localparam int REG_W = 4;

    // Default width of the saturating performance counters.
    localparam int CNT_W_DEFAULT = 16;

    // Memory-handshake sequencer states.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage : pipeline_pkg

// File: rtl/hazard_detect.sv
// Purely combinational register-dependence hazard check for the instruction in ID.
// With forwarding active only a load in EXE feeding ID can still stall (load-use).
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0] id_src1_i,
    input  logic [REG_W-1:0] id_src2_i,
    input  logic             id_use_src1_i,
    input  logic             id_two_src_i,
    input  logic             exe_wb_en_i,
    input  logic [REG_W-1:0] exe_dest_i,
    input  logic             exe_mem_read_i,
    input  logic             mem_wb_en_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             forward_en_i,
    output logic             hazard_o
);

    logic exe_hit1, exe_hit2, mem_hit1, mem_hit2;
    logic m1_exe, m2_exe, m1, m2;

    // Raw destination matches against each source operand.
    assign exe_hit1 = exe_wb_en_i & (exe_dest_i == id_src1_i);
    assign exe_hit2 = exe_wb_en_i & (exe_dest_i == id_src2_i);
    assign mem_hit1 = mem_wb_en_i & (mem_dest_i == id_src1_i);
    assign mem_hit2 = mem_wb_en_i & (mem_dest_i == id_src2_i);

    // Qualify by whether the ID instruction actually reads each operand.
    assign m1_exe = id_use_src1_i & exe_hit1;
    assign m2_exe = id_two_src_i  & exe_hit2;
    assign m1     = id_use_src1_i & (exe_hit1 | mem_hit1);
    assign m2     = id_two_src_i  & (exe_hit2 | mem_hit2);

    // Forwarding covers every dependence except a load still in EXE.
    assign hazard_o = forward_en_i ? (exe_mem_read_i & exe_wb_en_i & (m1_exe | m2_exe))
                                   : (m1 | m2);

endmodule : hazard_detect

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller: combines memory stalls, taken branches and
// dependence hazards into freeze/flush controls, tracks the SRAM handshake with a
// two-state FSM and keeps saturating stall/flush counters for performance debug.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1_i,
    input  logic [REG_W-1:0] id_src2_i,
    input  logic             id_use_src1_i,
    input  logic             id_two_src_i,
    input  logic             exe_wb_en_i,
    input  logic [REG_W-1:0] exe_dest_i,
    input  logic             exe_mem_read_i,
    input  logic             mem_wb_en_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             forward_en_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             clr_cnt_i,
    output logic             freeze_pc_o,
    output logic             freeze_if_id_o,
    output logic             flush_if_id_o,
    output logic             flush_id_exe_o,
    output logic             freeze_back_o,
    output logic             mem_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard;
    logic             mem_stall;
    logic             freeze_front;

    hazard_detect u_hazard_detect (
        .id_src1_i      (id_src1_i),
        .id_src2_i      (id_src2_i),
        .id_use_src1_i  (id_use_src1_i),
        .id_two_src_i   (id_two_src_i),
        .exe_wb_en_i    (exe_wb_en_i),
        .exe_dest_i     (exe_dest_i),
        .exe_mem_read_i (exe_mem_read_i),
        .mem_wb_en_i    (mem_wb_en_i),
        .mem_dest_i     (mem_dest_i),
        .forward_en_i   (forward_en_i),
        .hazard_o       (hazard)
    );

    // A pending SRAM access stalls in its very first cycle, whatever the FSM state.
    assign mem_stall = mem_req_i & ~mem_ready_i;

    // Priority mem_stall > branch > hazard. A branch under a memory stall is held
    // (EXE is frozen) and flushes on the release cycle.
    assign freeze_front   = mem_stall | (hazard & ~branch_taken_i);
    assign freeze_pc_o    = freeze_front;
    assign freeze_if_id_o = freeze_front;
    assign flush_if_id_o  = branch_taken_i & ~mem_stall;
    assign flush_id_exe_o = ~mem_stall & (branch_taken_i | hazard);
    assign freeze_back_o  = mem_stall;
    assign mem_busy_o     = (state_q == MEM_WAIT);
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

    // Next-state logic for the memory-handshake FSM.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_stall) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ready_i || !mem_req_i) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Counter next values: clear wins over increment; increments saturate at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (freeze_front && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_if_id_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers; reset returns to RUN with cleared counters.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a table of combinational control vectors
// followed by hand-written multi-cycle sequences (load-use, branch flush, SRAM wait,
// counter saturation/clear, reset during MEM_WAIT).
module tb_pipeline_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    id_src1, id_src2, exe_dest, mem_dest;
    logic          id_use_src1, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
    logic          forward_en, branch_taken, mem_req, mem_ready, clr_cnt;
    logic          freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back, mem_busy;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       two;
        logic       exe_wb;
        logic [3:0] exe_dest;
        logic       exe_rd;
        logic       mem_wb;
        logic [3:0] mem_dest;
        logic       fwd;
        logic       br;
        logic       req;
        logic       rdy;
    } in_t;

    // Expected control outputs packed as {freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back}.
    typedef struct {
        string      name;
        in_t        i;
        logic [4:0] o;
    } vec_t;

    vec_t vecs[16];

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_src1_i      (id_src1),
        .id_src2_i      (id_src2),
        .id_use_src1_i  (id_use_src1),
        .id_two_src_i   (id_two_src),
        .exe_wb_en_i    (exe_wb_en),
        .exe_dest_i     (exe_dest),
        .exe_mem_read_i (exe_mem_read),
        .mem_wb_en_i    (mem_wb_en),
        .mem_dest_i     (mem_dest),
        .forward_en_i   (forward_en),
        .branch_taken_i (branch_taken),
        .mem_req_i      (mem_req),
        .mem_ready_i    (mem_ready),
        .clr_cnt_i      (clr_cnt),
        .freeze_pc_o    (freeze_pc),
        .freeze_if_id_o (freeze_if_id),
        .flush_if_id_o  (flush_if_id),
        .flush_id_exe_o (flush_id_exe),
        .freeze_back_o  (freeze_back),
        .mem_busy_o     (mem_busy),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t vi(input logic [3:0] src1, input logic [3:0] src2,
                               input logic use1, input logic two, input logic exe_wb,
                               input logic [3:0] edst, input logic exe_rd, input logic mem_wb,
                               input logic [3:0] mdst, input logic fwd, input logic br,
                               input logic req, input logic rdy);
        in_t r;
        r.src1 = src1; r.src2 = src2; r.use1 = use1; r.two = two; r.exe_wb = exe_wb;
        r.exe_dest = edst; r.exe_rd = exe_rd; r.mem_wb = mem_wb; r.mem_dest = mdst;
        r.fwd = fwd; r.br = br; r.req = req; r.rdy = rdy;
        return r;
    endfunction

    task automatic apply(input in_t v);
        id_src1 = v.src1; id_src2 = v.src2; id_use_src1 = v.use1; id_two_src = v.two;
        exe_wb_en = v.exe_wb; exe_dest = v.exe_dest; exe_mem_read = v.exe_rd;
        mem_wb_en = v.mem_wb; mem_dest = v.mem_dest; forward_en = v.fwd;
        branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
    endtask

    task automatic idle_inputs();
        apply('0);
        clr_cnt = 1'b0;
    endtask

    function automatic logic [4:0] ctl();
        return {freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back};
    endfunction

    // Move to just after the next rising edge, where inputs are changed.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        // name, inputs(src1,src2,use1,two,exe_wb,exe_dest,exe_rd,mem_wb,mem_dest,fwd,br,req,rdy), expected
        vecs[0]  = '{"idle",               vi(0,0,0,0,0,0,0,0,0,0,0,0,0), 5'b00000};
        vecs[1]  = '{"exe_raw_nofwd",      vi(3,0,1,0,1,3,0,0,0,0,0,0,0), 5'b11010};
        vecs[2]  = '{"exe_raw_src1_unused",vi(3,0,0,0,1,3,0,0,0,0,0,0,0), 5'b00000};
        vecs[3]  = '{"mem_raw_src2_nofwd", vi(0,5,0,1,0,0,0,1,5,0,0,0,0), 5'b11010};
        vecs[4]  = '{"mem_raw_src2_fwd",   vi(0,5,0,1,0,0,0,1,5,1,0,0,0), 5'b00000};
        vecs[5]  = '{"load_use_src1",      vi(3,0,1,0,1,3,1,0,0,1,0,0,0), 5'b11010};
        vecs[6]  = '{"alu_dep_fwd",        vi(3,0,1,0,1,3,0,0,0,1,0,0,0), 5'b00000};
        vecs[7]  = '{"load_src2_one_src",  vi(0,7,0,0,1,7,1,0,0,1,0,0,0), 5'b00000};
        vecs[8]  = '{"load_src2_two_src",  vi(0,7,0,1,1,7,1,0,0,1,0,0,0), 5'b11010};
        vecs[9]  = '{"branch_and_hazard",  vi(3,0,1,0,1,3,0,0,0,0,1,0,0), 5'b00110};
        vecs[10] = '{"branch_only",        vi(0,0,0,0,0,0,0,0,0,0,1,0,0), 5'b00110};
        vecs[11] = '{"stall_br_hazard",    vi(3,0,1,0,1,3,0,0,0,0,1,1,0), 5'b11001};
        vecs[12] = '{"single_cycle_mem_br",vi(0,0,0,0,0,0,0,0,0,0,1,1,1), 5'b00110};
        vecs[13] = '{"ready_no_req",       vi(0,0,0,0,0,0,0,0,0,0,0,0,1), 5'b00000};
        vecs[14] = '{"dest_mismatch",      vi(3,0,1,0,1,4,0,1,5,0,0,0,0), 5'b00000};
        vecs[15] = '{"mem_wb_disabled",    vi(3,0,1,0,0,0,0,0,3,0,0,0,0), 5'b00000};

        // Reset: all outputs zero during and after reset with inputs low.
        idle_inputs();
        rst = 1'b1;
        #12;
        check("rst_ctl_during", {27'd0, ctl()}, 32'd0);
        check("rst_busy_during", {31'd0, mem_busy}, 32'd0);
        check("rst_cnt_during", {24'd0, stall_cnt, flush_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rst_ctl_after", {27'd0, ctl()}, 32'd0);
        check("rst_busy_after", {31'd0, mem_busy}, 32'd0);

        // Combinational control table.
        for (int k = 0; k < 16; k++) begin
            next_cycle();
            apply(vecs[k].i);
            @(negedge clk);
            check(vecs[k].name, {27'd0, ctl()}, {27'd0, vecs[k].o});
        end

        // Load-use with forwarding: one stall cycle, counted the next cycle.
        do_reset();
        apply(vi(3,0,1,0,1,3,1,0,0,1,0,0,0));
        @(negedge clk);
        check("lu_freeze_pc", {31'd0, freeze_pc}, 32'd1);
        check("lu_flush_id_exe", {31'd0, flush_id_exe}, 32'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("lu_freeze_released", {31'd0, freeze_pc}, 32'd0);
        check("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);
        check("lu_flush_cnt", {28'd0, flush_cnt}, 32'd0);

        // Branch with a concurrent hazard: flush wins, no freeze.
        next_cycle();
        apply(vi(3,0,1,0,1,3,0,0,0,0,1,0,0));
        @(negedge clk);
        check("bh_ctl", {27'd0, ctl()}, {27'd0, 5'b00110});
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("bh_flush_cnt", {28'd0, flush_cnt}, 32'd1);
        check("bh_stall_cnt", {28'd0, stall_cnt}, 32'd1);

        // SRAM wait of 3 cycles with a branch pending throughout; ready in cycle 4.
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            apply(vi(0,0,0,0,0,0,0,0,0,0,1,1,0));
            @(negedge clk);
            check($sformatf("mw_c%0d_freeze_back", c), {31'd0, freeze_back}, 32'd1);
            check($sformatf("mw_c%0d_mem_busy", c), {31'd0, mem_busy}, (c == 1) ? 32'd0 : 32'd1);
            check($sformatf("mw_c%0d_no_flush", c), {30'd0, flush_if_id, flush_id_exe}, 32'd0);
            next_cycle();
        end
        apply(vi(0,0,0,0,0,0,0,0,0,0,1,1,1));
        @(negedge clk);
        check("mw_c4_ctl", {27'd0, ctl()}, {27'd0, 5'b00110});
        check("mw_c4_mem_busy", {31'd0, mem_busy}, 32'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("mw_c5_mem_busy", {31'd0, mem_busy}, 32'd0);
        check("mw_stall_cnt", {28'd0, stall_cnt}, 32'd3);
        check("mw_flush_cnt", {28'd0, flush_cnt}, 32'd1);

        // Saturation: 20 stall cycles hold a 4-bit counter at 15; clear wins next.
        do_reset();
        apply(vi(0,0,0,0,0,0,0,0,0,0,0,1,0));
        repeat (20) next_cycle();
        idle_inputs();
        @(negedge clk);
        check("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
        next_cycle();
        clr_cnt = 1'b1;
        mem_req = 1'b1;
        @(negedge clk);
        check("sat_before_clr", {28'd0, stall_cnt}, 32'd15);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("clr_stall_cnt", {28'd0, stall_cnt}, 32'd0);

        // Reset asserted in the 2nd MEM_WAIT cycle.
        do_reset();
        apply(vi(0,0,0,0,0,0,0,0,0,0,1,1,0));
        next_cycle();
        @(negedge clk);
        check("rmw_busy_before", {31'd0, mem_busy}, 32'd1);
        check("rmw_stall_before", {28'd0, stall_cnt}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rmw_busy_async", {31'd0, mem_busy}, 32'd0);
        check("rmw_cnt_async", {24'd0, stall_cnt, flush_cnt}, 32'd0);
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        apply(vi(0,0,0,0,0,0,0,0,0,0,0,1,0));
        @(negedge clk);
        check("rmw_resume_run", {31'd0, mem_busy}, 32'd0);
        check("rmw_resume_stall", {31'd0, freeze_back}, 32'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("rmw_resume_wait", {31'd0, mem_busy}, 32'd1);
        check("rmw_resume_cnt", {28'd0, stall_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pipeline_ctrl
